// File: rtl/axi_lite_cmd_pkg.sv
// Shared types and response codes for the AXI4-Lite command master.
package axi_lite_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_DATA,
        S_DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite single-outstanding command master.
// Turns one upstream command (read or write) into one AXI4-Lite transaction
// and reports completion with a one-cycle rsp_valid pulse.
// Optional build macro AXI_CMD_TIMEOUT_EN adds a slave-stall watchdog that
// aborts a transaction after TIMEOUT_CYCLES busy cycles with a DECERR code.
module axi_lite_cmd_master
    import axi_lite_cmd_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                        axi_aclk,
    input  logic                        axi_areset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [C_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]                 cmd_wdata,
    input  logic [3:0]                  cmd_wstrb,
    output logic                        rsp_valid,
    output logic [31:0]                 rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic [C_AXI_ADDR_WIDTH-1:0] axi_awaddr,
    output logic                        axi_awvalid,
    input  logic                        axi_awready,
    output logic [31:0]                 axi_wdata,
    output logic [3:0]                  axi_wstrb,
    output logic                        axi_wvalid,
    input  logic                        axi_wready,
    input  logic [1:0]                  axi_bresp,
    input  logic                        axi_bvalid,
    output logic                        axi_bready,
    output logic [C_AXI_ADDR_WIDTH-1:0] axi_araddr,
    output logic                        axi_arvalid,
    input  logic                        axi_arready,
    input  logic [31:0]                 axi_rdata,
    input  logic [1:0]                  axi_rresp,
    input  logic                        axi_rvalid,
    output logic                        axi_rready
);

    state_t                      state_q;
    logic                        rsp_valid_q;
    logic [31:0]                 rsp_rdata_q;
    logic [1:0]                  rsp_resp_q;
    logic [C_AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic                        awvalid_q;
    logic [31:0]                 wdata_q;
    logic [3:0]                  wstrb_q;
    logic                        wvalid_q;
    logic                        bready_q;
    logic [C_AXI_ADDR_WIDTH-1:0] araddr_q;
    logic                        arvalid_q;
    logic                        rready_q;

`ifdef AXI_CMD_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    logic [TIMER_W-1:0] timer_q;
`else
    // TIMEOUT_CYCLES only matters in the watchdog build; tie it off here.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // Accept only while idle, and never while reset is held.
    assign cmd_ready   = (state_q == S_IDLE) && !axi_areset;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign axi_awaddr  = awaddr_q;
    assign axi_awvalid = awvalid_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_wvalid  = wvalid_q;
    assign axi_bready  = bready_q;
    assign axi_araddr  = araddr_q;
    assign axi_arvalid = arvalid_q;
    assign axi_rready  = rready_q;

    // Transaction FSM: every AXI and response output is a register updated here.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
`ifdef AXI_CMD_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_write) begin
                            awaddr_q  <= cmd_addr;
                            wdata_q   <= cmd_wdata;
                            wstrb_q   <= cmd_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WR_REQ;
                        end else begin
                            araddr_q  <= cmd_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_REQ;
                        end
`ifdef AXI_CMD_TIMEOUT_EN
                        timer_q <= '0;
`endif
                    end
                end
                S_WR_REQ: begin
                    if (axi_awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (axi_wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if ((!awvalid_q || axi_awready) && (!wvalid_q || axi_wready)) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (axi_bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= axi_bresp;
                        state_q     <= S_DONE;
                    end
                end
                S_RD_REQ: begin
                    if (axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (axi_rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= axi_rdata;
                        rsp_resp_q  <= axi_rresp;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
`ifdef AXI_CMD_TIMEOUT_EN
            // A stalled slave overrides whatever the state logic decided above.
            if (state_q inside {S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA}) begin
                if (timer_q == TIMER_LAST) begin
                    awvalid_q   <= 1'b0;
                    wvalid_q    <= 1'b0;
                    bready_q    <= 1'b0;
                    arvalid_q   <= 1'b0;
                    rready_q    <= 1'b0;
                    rsp_rdata_q <= '0;
                    rsp_resp_q  <= RESP_DECERR;
                    state_q     <= S_DONE;
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Scoreboard bench for axi_lite_cmd_master with a configurable AXI4-Lite slave model.
// Honours AXI_CMD_TIMEOUT_EN to pick the stalled-slave expectation.
module tb_axi_lite_cmd_master;

    localparam int AW = 16;
    localparam int TO = 16;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          lat;
        int          acceptCycle;
    } rspExp_t;

    logic          clock;
    logic          reset;
    logic          cmdValid;
    logic          cmdReady;
    logic          cmdWrite;
    logic [AW-1:0] cmdAddr;
    logic [31:0]   cmdWdata;
    logic [3:0]    cmdWstrb;
    logic          rspValid;
    logic [31:0]   rspRdata;
    logic [1:0]    rspResp;
    logic [AW-1:0] axiAwaddr;
    logic          axiAwvalid;
    logic          axiAwready;
    logic [31:0]   axiWdata;
    logic [3:0]    axiWstrb;
    logic          axiWvalid;
    logic          axiWready;
    logic [1:0]    axiBresp;
    logic          axiBvalid;
    logic          axiBready;
    logic [AW-1:0] axiAraddr;
    logic          axiArvalid;
    logic          axiArready;
    logic [31:0]   axiRdata;
    logic [1:0]    axiRresp;
    logic          axiRvalid;
    logic          axiRready;

    int errors = 0;
    int checks = 0;
    int cycleCnt = 0;
    int rspCount = 0;
    int awHsCount = 0;
    int wHsCount = 0;

    // Slave configuration, set by the stimulus between transactions.
    int          awDelay = 0;
    int          wDelay = 0;
    int          bDelay = 0;
    int          arDelay = 0;
    int          rDelay = 0;
    logic [1:0]  slvBresp = 2'b00;
    logic [31:0] slvRdata = 32'h0;
    logic [1:0]  slvRresp = 2'b00;
    logic        allowDrop = 1'b0;

    // Values the DUT is expected to put on the AXI channels.
    logic [AW-1:0] expAddr = '0;
    logic [31:0]   expWdata = '0;
    logic [3:0]    expWstrb = '0;

    rspExp_t sbQ[$];
    rspExp_t monE;

    axi_lite_cmd_master #(
        .C_AXI_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .axi_aclk   (clock),
        .axi_areset (reset),
        .cmd_valid  (cmdValid),
        .cmd_ready  (cmdReady),
        .cmd_write  (cmdWrite),
        .cmd_addr   (cmdAddr),
        .cmd_wdata  (cmdWdata),
        .cmd_wstrb  (cmdWstrb),
        .rsp_valid  (rspValid),
        .rsp_rdata  (rspRdata),
        .rsp_resp   (rspResp),
        .axi_awaddr (axiAwaddr),
        .axi_awvalid(axiAwvalid),
        .axi_awready(axiAwready),
        .axi_wdata  (axiWdata),
        .axi_wstrb  (axiWstrb),
        .axi_wvalid (axiWvalid),
        .axi_wready (axiWready),
        .axi_bresp  (axiBresp),
        .axi_bvalid (axiBvalid),
        .axi_bready (axiBready),
        .axi_araddr (axiAraddr),
        .axi_arvalid(axiArvalid),
        .axi_arready(axiArready),
        .axi_rdata  (axiRdata),
        .axi_rresp  (axiRresp),
        .axi_rvalid (axiRvalid),
        .axi_rready (axiRready)
    );

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Cycle counter used to measure accept-to-response latency.
    always @(posedge clock) begin
        cycleCnt <= cycleCnt + 1;
    end

    // Slave address/data readiness: each ready rises after its configured wait.
    int awCnt = 0;
    int wCnt = 0;
    int arCnt = 0;
    always_comb begin
        axiAwready = axiAwvalid && (awCnt >= awDelay);
        axiWready  = axiWvalid && (wCnt >= wDelay);
        axiArready = axiArvalid && (arCnt >= arDelay);
    end

    // Slave wait counters for AW, W and AR.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            awCnt <= 0;
            wCnt  <= 0;
            arCnt <= 0;
        end else begin
            awCnt <= (axiAwvalid && !axiAwready) ? awCnt + 1 : 0;
            wCnt  <= (axiWvalid && !axiWready) ? wCnt + 1 : 0;
            arCnt <= (axiArvalid && !axiArready) ? arCnt + 1 : 0;
        end
    end

    // Slave write response: B follows once both AW and W have completed.
    logic awDone;
    logic wDone;
    int   bCnt;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            axiBvalid <= 1'b0;
            axiBresp  <= 2'b00;
            awDone    <= 1'b0;
            wDone     <= 1'b0;
            bCnt      <= 0;
        end else begin
            if (axiBvalid && axiBready) begin
                axiBvalid <= 1'b0;
            end else if ((awDone || (axiAwvalid && axiAwready)) &&
                         (wDone || (axiWvalid && axiWready)) && !axiBvalid) begin
                if (bCnt >= bDelay) begin
                    axiBvalid <= 1'b1;
                    axiBresp  <= slvBresp;
                    awDone    <= 1'b0;
                    wDone     <= 1'b0;
                    bCnt      <= 0;
                end else begin
                    bCnt   <= bCnt + 1;
                    awDone <= 1'b1;
                    wDone  <= 1'b1;
                end
            end else begin
                awDone <= awDone || (axiAwvalid && axiAwready);
                wDone  <= wDone || (axiWvalid && axiWready);
            end
        end
    end

    // Slave read data: R follows the AR handshake after the configured wait.
    logic arDone;
    int   rCnt;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            axiRvalid <= 1'b0;
            axiRdata  <= '0;
            axiRresp  <= 2'b00;
            arDone    <= 1'b0;
            rCnt      <= 0;
        end else begin
            if (axiRvalid && axiRready) begin
                axiRvalid <= 1'b0;
            end else if ((arDone || (axiArvalid && axiArready)) && !axiRvalid) begin
                if (rCnt >= rDelay) begin
                    axiRvalid <= 1'b1;
                    axiRdata  <= slvRdata;
                    axiRresp  <= slvRresp;
                    arDone    <= 1'b0;
                    rCnt      <= 0;
                end else begin
                    rCnt   <= rCnt + 1;
                    arDone <= 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     name, actual, expected, cycleCnt);
        end
    endtask

    // Monitor: response scoreboard, channel payloads, valid hold/drop and ready phases.
    logic          prevAwPend = 1'b0;
    logic          prevWPend = 1'b0;
    logic          prevArPend = 1'b0;
    logic          prevAwHs = 1'b0;
    logic          prevWHs = 1'b0;
    logic          prevArHs = 1'b0;
    logic [AW-1:0] prevAwaddr = '0;
    logic [35:0]   prevWbeat = '0;
    logic [AW-1:0] prevAraddr = '0;
    logic          awSeen = 1'b0;
    logic          wSeen = 1'b0;
    logic          bPhase = 1'b0;
    logic          rPhase = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            prevAwPend = 1'b0;
            prevWPend  = 1'b0;
            prevArPend = 1'b0;
            prevAwHs   = 1'b0;
            prevWHs    = 1'b0;
            prevArHs   = 1'b0;
            awSeen     = 1'b0;
            wSeen      = 1'b0;
            bPhase     = 1'b0;
            rPhase     = 1'b0;
        end else begin
            if (rspValid) begin
                rspCount++;
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rsp_unexpected: got rsp_valid=1 expected no response at cycle %0d",
                             cycleCnt);
                end else begin
                    monE = sbQ.pop_front();
                    checkOutput("rsp_rdata", rspRdata, monE.rdata);
                    checkOutput("rsp_resp", rspResp, monE.resp);
                    if (monE.lat > 0) begin
                        checkOutput("rsp_latency", cycleCnt - monE.acceptCycle, monE.lat);
                    end
                end
            end
            if (prevAwPend && !allowDrop) checkOutput("aw_hold", {axiAwvalid, axiAwaddr}, {1'b1, prevAwaddr});
            if (prevWPend && !allowDrop) checkOutput("w_hold", {axiWvalid, axiWdata, axiWstrb}, {1'b1, prevWbeat});
            if (prevArPend && !allowDrop) checkOutput("ar_hold", {axiArvalid, axiAraddr}, {1'b1, prevAraddr});
            if (prevAwHs) checkOutput("aw_drop", axiAwvalid, 1'b0);
            if (prevWHs) checkOutput("w_drop", axiWvalid, 1'b0);
            if (prevArHs) checkOutput("ar_drop", axiArvalid, 1'b0);
            checkOutput("bready_phase", axiBready, bPhase);
            checkOutput("rready_phase", axiRready, rPhase);
            if (axiAwvalid && axiAwready) begin
                awHsCount++;
                awSeen = 1'b1;
                checkOutput("awaddr", axiAwaddr, expAddr);
            end
            if (axiWvalid && axiWready) begin
                wHsCount++;
                wSeen = 1'b1;
                checkOutput("wdata_wstrb", {axiWdata, axiWstrb}, {expWdata, expWstrb});
            end
            if (axiArvalid && axiArready) begin
                rPhase = 1'b1;
                checkOutput("araddr", axiAraddr, expAddr);
            end
            if (axiBvalid && axiBready) bPhase = 1'b0;
            if (axiRvalid && axiRready) rPhase = 1'b0;
            if (awSeen && wSeen) begin
                bPhase = 1'b1;
                awSeen = 1'b0;
                wSeen  = 1'b0;
            end
            prevAwPend = axiAwvalid && !axiAwready;
            prevWPend  = axiWvalid && !axiWready;
            prevArPend = axiArvalid && !axiArready;
            prevAwHs   = axiAwvalid && axiAwready;
            prevWHs    = axiWvalid && axiWready;
            prevArHs   = axiArvalid && axiArready;
            prevAwaddr = axiAwaddr;
            prevWbeat  = {axiWdata, axiWstrb};
            prevAraddr = axiAraddr;
        end
    end

    // Issue one command; on acceptance optionally queue its expected response.
    task automatic applyStimulus(input logic write, input logic [AW-1:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb,
                                 input logic [31:0] expRdata, input logic [1:0] expResp,
                                 input int expLat, input logic pushRsp);
        bit accepted = 0;
        @(posedge clock);
        #1;
        expAddr  = addr;
        expWdata = wdata;
        expWstrb = wstrb;
        cmdWrite = write;
        cmdAddr  = addr;
        cmdWdata = wdata;
        cmdWstrb = wstrb;
        cmdValid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (cmdReady) begin
                accepted = 1;
                if (pushRsp) sbQ.push_back('{expRdata, expResp, expLat, cycleCnt});
                break;
            end
        end
        @(posedge clock);
        #1;
        cmdValid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL cmd_accept: got no cmd_ready within 100 cycles expected acceptance");
        end
    endtask

    task automatic waitDone(input string tag);
        bit done = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (sbQ.size() == 0) begin
                done = 1;
                break;
            end
        end
        @(negedge clock);
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got %0d pending responses expected 0 within 200 cycles", tag, sbQ.size());
        end
    endtask

    task automatic pulseReset();
        @(posedge clock);
        #2;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        sbQ.delete();
    endtask

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        int snapAw;
        int snapW;
        int snapRsp;
        cmdValid = 1'b0;
        cmdWrite = 1'b0;
        cmdAddr  = '0;
        cmdWdata = '0;
        cmdWstrb = '0;
        reset    = 1'b0;
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_cmd_ready", cmdReady, 1'b0);
        checkOutput("reset_outputs",
                    {rspValid, rspRdata, rspResp, axiAwaddr, axiAwvalid, axiWdata, axiWstrb,
                     axiWvalid, axiBready, axiAraddr, axiArvalid, axiRready}, '0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("cmd_ready_after_release", cmdReady, 1'b1);

        $display("[TB] write 0x960, slave always ready");
        snapAw = awHsCount;
        snapW  = wHsCount;
        applyStimulus(1'b1, 16'h0960, 32'h001F6000, 4'hF, 32'h0, 2'b00, 4, 1'b1);
        waitDone("write_fast_done");
        checkOutput("write_fast_aw_count", awHsCount - snapAw, 1);
        checkOutput("write_fast_w_count", wHsCount - snapW, 1);

        $display("[TB] write with wready 3 cycles after awready, SLVERR");
        wDelay   = 3;
        slvBresp = 2'b10;
        snapAw   = awHsCount;
        snapW    = wHsCount;
        snapRsp  = rspCount;
        applyStimulus(1'b1, 16'h0A24, 32'hDEADBEEF, 4'h5, 32'h0, 2'b10, 7, 1'b1);
        waitDone("write_split_done");
        checkOutput("write_split_aw_count", awHsCount - snapAw, 1);
        checkOutput("write_split_w_count", wHsCount - snapW, 1);
        checkOutput("write_split_rsp_count", rspCount - snapRsp, 1);
        wDelay   = 0;
        slvBresp = 2'b00;

        $display("[TB] read 0x004 with two data wait cycles");
        rDelay   = 2;
        slvRdata = 32'h00000001;
        applyStimulus(1'b0, 16'h0004, 32'h0, 4'h0, 32'h00000001, 2'b00, 6, 1'b1);
        waitDone("read_wait_done");
        rDelay = 0;

        $display("[TB] read 0x1234 with AR wait and SLVERR");
        arDelay  = 1;
        slvRdata = 32'hCAFEF00D;
        slvRresp = 2'b10;
        applyStimulus(1'b0, 16'h1234, 32'h0, 4'h0, 32'hCAFEF00D, 2'b10, 5, 1'b1);
        waitDone("read_arwait_done");
        arDelay  = 0;
        slvRresp = 2'b00;

        $display("[TB] reset while waiting for write response");
        bDelay = 20;
        applyStimulus(1'b1, 16'h0ABC, 32'h55AA55AA, 4'h3, 32'h0, 2'b00, 0, 1'b0);
        begin
            bit sawBready = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clock);
                if (axiBready) begin
                    sawBready = 1;
                    break;
                end
            end
            checkOutput("wr_resp_reached", sawBready, 1'b1);
        end
        repeat (2) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_outputs",
                    {cmdReady, rspValid, rspRdata, rspResp, axiAwaddr, axiAwvalid, axiWdata, axiWstrb,
                     axiWvalid, axiBready, axiAraddr, axiArvalid, axiRready}, '0);
        snapRsp = rspCount;
        repeat (2) @(posedge clock);
        #1;
        reset  = 1'b0;
        bDelay = 0;
        sbQ.delete();
        repeat (3) @(negedge clock);
        checkOutput("no_rsp_after_reset", rspCount - snapRsp, 0);
        applyStimulus(1'b1, 16'h0ABC, 32'h12345678, 4'hC, 32'h0, 2'b00, 4, 1'b1);
        waitDone("post_reset_write_done");

        $display("[TB] read with arready held low");
        arDelay = 1000000;
`ifdef AXI_CMD_TIMEOUT_EN
        allowDrop = 1'b1;
        applyStimulus(1'b0, 16'h0100, 32'h0, 4'h0, 32'h0, 2'b11, TO + 2, 1'b1);
        waitDone("timeout_done");
        allowDrop = 1'b0;
        arDelay   = 0;
`else
        snapRsp = rspCount;
        applyStimulus(1'b0, 16'h0100, 32'h0, 4'h0, 32'h0, 2'b00, 0, 1'b0);
        repeat (1000) @(negedge clock);
        checkOutput("no_timeout_rsp", rspCount - snapRsp, 0);
        checkOutput("arvalid_still_held", axiArvalid, 1'b1);
        pulseReset();
        arDelay = 0;
`endif

        $display("[TB] recovery read 0x200");
        slvRdata = 32'h0BADBEEF;
        applyStimulus(1'b0, 16'h0200, 32'h0, 4'h0, 32'h0BADBEEF, 2'b00, 4, 1'b1);
        waitDone("recovery_read_done");

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_cmd_master.md
AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 SHALL have parameter C_AXI_ADDR_WIDTH, default 16, AXI byte-address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, slave-stall limit (timeout build only).
REQ-003 SHALL have port axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port axi_areset  in  1  reset; asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  in  1  upstream command present.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
REQ-007 SHALL have port cmd_write  in  1  1=write, 0=read.
REQ-008 SHALL have port cmd_addr  in  C_AXI_ADDR_WIDTH  byte address.
REQ-009 SHALL have port cmd_wdata  in  32  write data.
REQ-010 SHALL have port cmd_wstrb  in  4  byte strobes.
REQ-011 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  out  32  read data, valid with rsp_valid.
REQ-013 SHALL have port rsp_resp  out  2  BRESP/RRESP or timeout code.
REQ-014 SHALL have port axi_awaddr  out  C_AXI_ADDR_WIDTH  write address.
REQ-015 SHALL have port axi_awvalid  out  1  AW valid.
REQ-016 SHALL have port axi_awready  in  1  AW ready.
REQ-017 SHALL have port axi_wdata  out  32  write data.
REQ-018 SHALL have port axi_wstrb  out  4  write strobes.
REQ-019 SHALL have port axi_wvalid  out  1  W valid.
REQ-020 SHALL have port axi_wready  in  1  W ready.
REQ-021 SHALL have port axi_bresp  in  2  write response.
REQ-022 SHALL have port axi_bvalid  in  1  B valid.
REQ-023 SHALL have port axi_bready  out  1  B ready.
REQ-024 SHALL have port axi_araddr  out  C_AXI_ADDR_WIDTH  read address.
REQ-025 SHALL have port axi_arvalid  out  1  AR valid.
REQ-026 SHALL have port axi_arready  in  1  AR ready.
REQ-027 SHALL have port axi_rdata  in  32  read data.
REQ-028 SHALL have port axi_rresp  in  2  read response.
REQ-029 SHALL have port axi_rvalid  in  1  R valid.
REQ-030 SHALL have port axi_rready  out  1  R ready.

Function
REQ-031 SHALL implement FSM IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE; cmd_ready=1 only in IDLE; one transaction outstanding max.
REQ-032 SHALL on accept register addr/wdata/wstrb, go IDLE->WR_REQ (write) or RD_REQ (read); AXI valids assert the cycle after accept.
REQ-033 SHALL in WR_REQ hold awvalid and wvalid independently, dropping each the cycle after its own handshake (same-cycle or either order), then go WR_RESP once both done.
REQ-034 SHALL in WR_RESP hold bready=1, capture bresp on bvalid, go DONE; in RD_REQ drop arvalid after arready, go RD_DATA; in RD_DATA hold rready=1, capture rdata/rresp on rvalid, go DONE.
REQ-035 SHALL in DONE pulse rsp_valid for exactly one cycle, return to IDLE; minimum accept-to-rsp_valid latency 4 cycles with always-ready slave; rsp_rdata=0 for writes.
REQ-036 SHALL never deassert a valid before its handshake and never change axi_* address/data/strobes while the corresponding valid is high.

Reset
REQ-037 SHALL on axi_areset (any cycle, including mid-transaction) force IDLE, all AXI valids/readies 0, rsp_valid 0, rsp_rdata 0, rsp_resp 0, address/data/strobe outputs 0; cmd_ready 0 during reset, 1 first cycle after release.

Configuration
REQ-038 SHALL with AXI_CMD_TIMEOUT_EN defined count cycles in WR_REQ/WR_RESP/RD_REQ/RD_DATA; on reaching TIMEOUT_CYCLES drop all valids/readies, go DONE with rsp_resp=2'b11 (debug only); without the macro no counter exists and the master waits indefinitely.

Structure
REQ-039 SHALL place the FSM state enum and response codes (OKAY=2'b00, DECERR=2'b11) in package axi_lite_cmd_pkg; no sub-module.

Verification
REQ-040 SHALL cover: write 0x960/0x001F6000 strb F, slave readies same cycle -> single AW+W handshake, rsp_valid 4 cycles after accept, rsp_resp 0.
REQ-041 SHALL cover: write with awready 3 cycles before wready -> awvalid drops after AW handshake, wvalid held until W handshake, one rsp_valid.
REQ-042 SHALL cover: read 0x004, slave returns rdata=1 after 2 wait cycles -> rsp_rdata=0x00000001, rsp_resp 0, rready high only in RD_DATA.
REQ-043 SHALL cover: axi_areset asserted while WR_RESP awaits bvalid -> all outputs 0 asynchronously, no rsp_valid, next command executes normally.
REQ-044 SHALL cover: AXI_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready held 0 -> rsp_valid at cycle 16 of RD_REQ with rsp_resp=2'b11; without macro no rsp_valid after 1000 cycles.
